// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for the sequential ALU.
// The producer/consumer side uses master; the ALU itself uses slave.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, zero, carry, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, zero, carry, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: SUB/ADD/NAND in one cycle, SHL/SHR one bit per cycle,
// MUL by shift-add over WIDTH cycles. Results and flags are held until accepted.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_SUB  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH:0]     mul_hi_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH-1:0]   shl_next_s;
    logic [WIDTH-1:0]   shr_next_s;
    logic [SW-1:0]      shamt_s;
    logic               last_s;

    assign sum_s      = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_s     = {1'b0, bus.b} - {1'b0, bus.a};
    // acc holds {partial product high, remaining multiplier bits}; add then shift right.
    assign mul_hi_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_hi_s, acc_q[WIDTH-1:1]};
    assign shl_next_s = {acc_q[WIDTH-2:0], 1'b0};
    assign shr_next_s = {1'b0, acc_q[WIDTH-1:1]};
    assign shamt_s    = bus.a[SW-1:0];
    assign last_s     = (cnt_q == CNT_ONE);

    // Next-state and datapath updates for IDLE/BUSY/DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d  = bus.a;
                    op_d = bus.op;
                    case (bus.op)
                        OP_SUB: begin
                            out_d   = diff_s[WIDTH-1:0];
                            carry_d = ~diff_s[WIDTH];
                            zero_d  = ~|out_d;
                            state_d = S_DONE;
                        end
                        OP_ADD: begin
                            out_d   = sum_s[WIDTH-1:0];
                            carry_d = sum_s[WIDTH];
                            zero_d  = ~|out_d;
                            state_d = S_DONE;
                        end
                        OP_NAND: begin
                            out_d   = ~(bus.a & bus.b);
                            carry_d = 1'b0;
                            zero_d  = ~|out_d;
                            state_d = S_DONE;
                        end
                        OP_SHL, OP_SHR: begin
                            acc_d = {{WIDTH{1'b0}}, bus.b};
                            cnt_d = {1'b0, shamt_s};
                            if (shamt_s == {SW{1'b0}}) begin
                                out_d   = bus.b;
                                carry_d = 1'b0;
                                zero_d  = ~|out_d;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_BUSY;
                            end
                        end
                        OP_MUL: begin
                            acc_d   = {{WIDTH{1'b0}}, bus.b};
                            cnt_d   = CNT_MUL;
                            state_d = S_BUSY;
                        end
                        default: begin
                            out_d   = {WIDTH{1'b0}};
                            carry_d = 1'b0;
                            zero_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                case (op_q)
                    OP_SHL: begin
                        acc_d = {{WIDTH{1'b0}}, shl_next_s};
                        if (last_s) begin
                            out_d   = shl_next_s;
                            carry_d = acc_q[WIDTH-1];
                            zero_d  = ~|out_d;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                    OP_SHR: begin
                        acc_d = {{WIDTH{1'b0}}, shr_next_s};
                        if (last_s) begin
                            out_d   = shr_next_s;
                            carry_d = acc_q[0];
                            zero_d  = ~|out_d;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                    OP_MUL: begin
                        acc_d = mul_next_s;
                        if (last_s) begin
                            out_d   = mul_next_s[WIDTH-1:0];
                            carry_d = |mul_next_s[2*WIDTH-1:WIDTH];
                            zero_d  = ~|out_d;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                    default: begin
                        out_d   = {WIDTH{1'b0}};
                        carry_d = 1'b0;
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            op_q        <= 3'd0;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            out_q       <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d == S_BUSY);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a behavioural model tracks the expected
// handshake phase and result every cycle; directed cases pin known values.
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    typedef struct packed {
        logic [W-1:0] o;
        logic         c;
        logic [7:0]   lat;
    } res_t;

    // Result and latency straight from the arithmetic definition of each op.
    function automatic res_t ref_calc(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [2:0] rop);
        res_t        r;
        int unsigned full;
        int          n;
        r.o = '0; r.c = 1'b0; r.lat = 8'd1;
        n = int'(ra) % W;
        case (rop)
            3'd0: begin r.o = rb - ra; r.c = (rb >= ra); end
            3'd1: begin full = int'(ra) + int'(rb); r.o = W'(full); r.c = (full >= (1 << W)); end
            3'd2: begin r.o = ~(ra & rb); r.c = 1'b0; end
            3'd3: begin
                if (n == 0) begin r.o = rb; r.c = 1'b0; end
                else begin
                    full = int'(rb) << n; r.o = W'(full); r.c = ((full >> W) & 1) != 0; r.lat = 8'(n + 1);
                end
            end
            3'd4: begin
                if (n == 0) begin r.o = rb; r.c = 1'b0; end
                else begin
                    r.o = rb >> n; r.c = ((int'(rb) >> (n - 1)) & 1) != 0; r.lat = 8'(n + 1);
                end
            end
            3'd5: begin full = int'(ra) * int'(rb); r.o = W'(full); r.c = (full >> W) != 0; r.lat = 8'(W + 1); end
            default: begin r.o = '0; r.c = 1'b0; end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 computing, 2 result held.
    int           m_phase;
    int           m_left;
    logic [W-1:0] m_out, p_out;
    logic         m_zero, m_carry, p_carry;
    res_t         res_now;

    always_comb res_now = ref_calc(bus.a, bus.b, bus.op);

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0; m_out <= '0; m_zero <= 1'b0; m_carry <= 1'b0; m_left <= 0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    if (res_now.lat == 8'd1) begin
                        m_phase <= 2; m_out <= res_now.o; m_carry <= res_now.c; m_zero <= (res_now.o == '0);
                    end else begin
                        m_phase <= 1; m_left <= int'(res_now.lat) - 1; p_out <= res_now.o; p_carry <= res_now.c;
                    end
                end
                1: if (m_left == 1) begin
                    m_phase <= 2; m_out <= p_out; m_carry <= p_carry; m_zero <= (p_out == '0);
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (bus.out_ready) m_phase <= 0;
            endcase
        end
    end

    // Compare process: every cycle, status and held result against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
            check("busy",      32'(bus.busy),      32'(m_phase == 1));
            check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            check("out",       32'(bus.out),       32'(m_out));
            check("zero",      32'(bus.zero),      32'(m_zero));
            check("carry",     32'(bus.carry),     32'(m_carry));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage();
        bus.in_valid = 1'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op       = 3'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [2:0] top, input int hold,
                          output logic [W-1:0] o, output logic c, output logic z, output int lat);
        int guard = 0;
        bus.in_valid = 1'b0;
        while (!bus.in_ready && guard < 100) begin cyc(); guard++; end
        check("wait_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.a = ta; bus.b = tbv; bus.op = top;
        cyc();
        lat = 1;
        garbage();
        while (!bus.out_valid && lat < 40) begin cyc(); lat++; garbage(); end
        check("wait_out_valid", 32'(bus.out_valid), 32'd1);
        o = bus.out; c = bus.carry; z = bus.zero;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            cyc();
            garbage();
            check("hold_out",      32'(bus.out),      32'(o));
            check("hold_carry",    32'(bus.carry),    32'(c));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("post_hs_in_ready",  32'(bus.in_ready),  32'd1);
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [2:0] top,
                            input logic [W-1:0] eo, input logic ec, input logic ez, input int elat, input int hold);
        logic [W-1:0] o;
        logic         c, z;
        int           lat;
        res_t         r;
        r = ref_calc(ta, tbv, top);
        check("model_out",   32'(r.o),   32'(eo));
        check("model_carry", 32'(r.c),   32'(ec));
        check("model_lat",   32'(r.lat), 32'(elat));
        run_op(ta, tbv, top, hold, o, c, z, lat);
        check("dir_out",     32'(o),   32'(eo));
        check("dir_carry",   32'(c),   32'(ec));
        check("dir_zero",    32'(z),   32'(ez));
        check("dir_latency", 32'(lat), 32'(elat));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] o;
        logic         c, z;
        int           lat;
        res_t         r;

        reset = 1'b1;
        bus.in_valid = 1'b1; bus.a = 8'h05; bus.b = 8'h03; bus.op = 3'd1; bus.out_ready = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out",       32'(bus.out),       32'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        cyc();

        directed(8'h05, 8'h03, 3'd0, 8'hFE, 1'b0, 1'b0, 1, 0);
        directed(8'h03, 8'h03, 3'd0, 8'h00, 1'b1, 1'b1, 1, 0);
        directed(8'hFF, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1, 1, 0);
        directed(8'hF0, 8'hFF, 3'd2, 8'h0F, 1'b0, 1'b0, 1, 0);
        directed(8'h12, 8'h34, 3'd6, 8'h00, 1'b0, 1'b1, 1, 0);
        directed(8'h03, 8'h81, 3'd3, 8'h08, 1'b0, 1'b0, 4, 0);
        directed(8'h01, 8'h81, 3'd4, 8'h40, 1'b1, 1'b0, 2, 0);
        directed(8'h00, 8'h5A, 3'd3, 8'h5A, 1'b0, 1'b0, 1, 0);
        directed(8'h10, 8'h10, 3'd5, 8'h00, 1'b1, 1'b1, 9, 0);
        directed(8'h07, 8'h09, 3'd5, 8'h3F, 1'b0, 1'b0, 9, 0);

        // Backpressure with changing inputs, then a normal op afterwards.
        directed(8'hC8, 8'h64, 3'd1, 8'h2C, 1'b1, 1'b0, 1, 5);
        directed(8'h02, 8'h03, 3'd1, 8'h05, 1'b0, 1'b0, 1, 0);

        // Reset in cycle T+3 of a MUL.
        bus.in_valid = 1'b1; bus.a = 8'h10; bus.b = 8'h10; bus.op = 3'd5;
        cyc();
        bus.in_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_out",       32'(bus.out),       32'd0);
        check("abort_carry",     32'(bus.carry),     32'd0);
        check("abort_zero",      32'(bus.zero),      32'd0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("abort_no_stale_valid", 32'(bus.out_valid), 32'd0);
        end
        directed(8'h02, 8'h03, 3'd1, 8'h05, 1'b0, 1'b0, 1, 0);

        // Randomized traffic: mixed ops, idle gaps and backpressure.
        for (int t = 0; t < 150; t++) begin
            logic [W-1:0] ra, rb;
            logic [2:0]   rop;
            int           gap;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 3'($urandom_range(0, 7));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc();
            r = ref_calc(ra, rb, rop);
            run_op(ra, rb, rop, $urandom_range(0, 3), o, c, z, lat);
            check("rnd_out",     32'(o),   32'(r.o));
            check("rnd_carry",   32'(c),   32'(r.c));
            check("rnd_latency", 32'(lat), 32'(r.lat));
        end

        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
